// File: rtl/calc_result_bcd.sv
// Sequential double-dabble converter: turns the calculator result and the
// division remainder into BCD digits, optionally blanking leading zeros.
module calc_result_bcd #(
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] result,
    input  logic [3:0] remainder,
    output logic [3:0] bcd_hun,
    output logic [3:0] bcd_ten,
    output logic [3:0] bcd_one,
    output logic [3:0] rem_ten,
    output logic [3:0] rem_one,
    output logic       neg,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_DIV  = 2'b11;
    localparam logic [3:0] BLANK     = 4'hF;

    logic [1:0]  state_r;
    logic [2:0]  cnt_r;
    logic [1:0]  mode_r;
    logic        neg_next_r;
    logic [7:0]  bin_r;
    logic [3:0]  rbin_r;
    logic [11:0] bcd_r;
    logic [7:0]  rbcd_r;

    logic [3:0]  twos_s;
    logic [7:0]  cap_val_s;
    logic        cap_neg_s;
    logic [3:0]  ten_adj_s;
    logic [3:0]  one_adj_s;
    logic [3:0]  rone_adj_s;
    logic [11:0] bcd_nxt_s;
    logic [7:0]  rbcd_nxt_s;
    logic [3:0]  hun_s;
    logic [3:0]  ten_s;
    logic [3:0]  rten_s;
    logic [3:0]  rone_s;

    function automatic logic [3:0] dd_adj(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

    // Conversion value and sign as seen on the start edge (sub shows magnitude of a borrow)
    always_comb begin
        twos_s    = ~result[3:0] + 4'd1;
        cap_val_s = result;
        cap_neg_s = 1'b0;
        if (mode == MODE_SUB) begin
            if (result[4]) begin
                cap_val_s = {4'd0, twos_s};
                cap_neg_s = 1'b1;
            end else begin
                cap_val_s = {4'd0, result[3:0]};
                cap_neg_s = 1'b0;
            end
        end else begin
            cap_val_s = result;
            cap_neg_s = 1'b0;
        end
    end

    // One double-dabble step. Hundreds (max 2) and remainder tens (max 1)
    // can never reach 5, so their add-3 correction is the identity.
    always_comb begin
        ten_adj_s  = dd_adj(bcd_r[7:4]);
        one_adj_s  = dd_adj(bcd_r[3:0]);
        rone_adj_s = dd_adj(rbcd_r[3:0]);
        bcd_nxt_s  = {bcd_r[10:8], ten_adj_s, one_adj_s, bin_r[7]};
        rbcd_nxt_s = {rbcd_r[6:4], rone_adj_s, rbin_r[3]};
    end

    // Leading-zero blanking and remainder suppression for non-divide ops
    always_comb begin
        hun_s  = bcd_r[11:8];
        ten_s  = bcd_r[7:4];
        rten_s = rbcd_r[7:4];
        rone_s = rbcd_r[3:0];
        if (BLANK_LEAD && (bcd_r[11:8] == 4'd0)) begin
            hun_s = BLANK;
            if (bcd_r[7:4] == 4'd0) begin
                ten_s = BLANK;
            end else begin
                ten_s = bcd_r[7:4];
            end
        end else begin
            hun_s = bcd_r[11:8];
            ten_s = bcd_r[7:4];
        end
        if (mode_r != MODE_DIV) begin
            rten_s = BLANK_LEAD ? BLANK : 4'd0;
            rone_s = BLANK_LEAD ? BLANK : 4'd0;
        end else if (BLANK_LEAD && (rbcd_r[7:4] == 4'd0)) begin
            rten_s = BLANK;
            rone_s = rbcd_r[3:0];
        end else begin
            rten_s = rbcd_r[7:4];
            rone_s = rbcd_r[3:0];
        end
    end

    // Control FSM, scratch shifting and registered digit outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            mode_r     <= 2'd0;
            neg_next_r <= 1'b0;
            bin_r      <= 8'd0;
            rbin_r     <= 4'd0;
            bcd_r      <= 12'd0;
            rbcd_r     <= 8'd0;
            bcd_hun    <= 4'd0;
            bcd_ten    <= 4'd0;
            bcd_one    <= 4'd0;
            rem_ten    <= 4'd0;
            rem_one    <= 4'd0;
            neg        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    // a start seen while done is still high is dropped
                    if (start && !done) begin
                        mode_r     <= mode;
                        bin_r      <= cap_val_s;
                        neg_next_r <= cap_neg_s;
                        rbin_r     <= remainder;
                        bcd_r      <= 12'd0;
                        rbcd_r     <= 8'd0;
                        cnt_r      <= 3'd0;
                        busy       <= 1'b1;
                        state_r    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_r <= bcd_nxt_s;
                    bin_r <= {bin_r[6:0], 1'b0};
                    if (!cnt_r[2]) begin
                        rbcd_r <= rbcd_nxt_s;
                        rbin_r <= {rbin_r[2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        state_r <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    bcd_hun <= hun_s;
                    bcd_ten <= ten_s;
                    bcd_one <= bcd_r[3:0];
                    rem_ten <= rten_s;
                    rem_one <= rone_s;
                    neg     <= neg_next_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_result_bcd.sv
// Self-checking bench for calc_result_bcd: arithmetic reference model compared
// every cycle, plus directed vectors with hand-computed digits.
module tb_calc_result_bcd;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       start     = 1'b0;
    logic [1:0] mode      = 2'b00;
    logic [7:0] result    = 8'd0;
    logic [3:0] remainder = 4'd0;

    logic [3:0] h1, t1, o1, rt1, ro1, h0, t0, o0, rt0, ro0;
    logic       neg1, busy1, done1, neg0, busy0, done0;
    logic [20:0] out1, out0;

    int n_chk = 0;
    int n_err = 0;

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [3:0]  m_left = 4'd0;
    logic [1:0]  m_mode = 2'b00;
    logic [7:0]  m_val  = 8'd0;
    logic [3:0]  m_rem  = 4'd0;
    logic        m_neg  = 1'b0;
    logic [20:0] m_out1 = 21'd0;
    logic [20:0] m_out0 = 21'd0;

    always #5 clk = ~clk;

    calc_result_bcd #(.BLANK_LEAD(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .result(result),
        .remainder(remainder), .bcd_hun(h1), .bcd_ten(t1), .bcd_one(o1),
        .rem_ten(rt1), .rem_one(ro1), .neg(neg1), .busy(busy1), .done(done1)
    );

    calc_result_bcd #(.BLANK_LEAD(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .result(result),
        .remainder(remainder), .bcd_hun(h0), .bcd_ten(t0), .bcd_one(o0),
        .rem_ten(rt0), .rem_one(ro0), .neg(neg0), .busy(busy0), .done(done0)
    );

    assign out1 = {h1, t1, o1, rt1, ro1, neg1};
    assign out0 = {h0, t0, o0, rt0, ro0, neg0};

    // magnitude and sign the calculator result stands for
    function automatic logic [8:0] cap(input logic [1:0] md, input logic [7:0] res);
        logic [3:0] mag;
        if (md == 2'b01 && res[4]) begin
            mag = 4'd0 - res[3:0];
            return {1'b1, 4'h0, mag};
        end else if (md == 2'b01) begin
            return {1'b0, 4'h0, res[3:0]};
        end else begin
            return {1'b0, res};
        end
    endfunction

    // expected display {hun,ten,one,rem_ten,rem_one,neg} from plain decimal arithmetic
    function automatic logic [20:0] fmt(input logic [7:0] v, input logic [1:0] md,
                                        input logic [3:0] r, input logic ng, input bit blank);
        int h, t, o, rt, ro;
        logic [3:0] dh, dt, dn, drt, dro;
        h  = int'(v) / 100;
        t  = (int'(v) / 10) % 10;
        o  = int'(v) % 10;
        rt = int'(r) / 10;
        ro = int'(r) % 10;
        dh = (blank && h == 0) ? 4'hF : 4'(h);
        dt = (blank && h == 0 && t == 0) ? 4'hF : 4'(t);
        dn = 4'(o);
        if (md != 2'b11) begin
            drt = blank ? 4'hF : 4'h0;
            dro = drt;
        end else begin
            drt = (blank && rt == 0) ? 4'hF : 4'(rt);
            dro = 4'(ro);
        end
        return {dh, dt, dn, drt, dro, ng};
    endfunction

    // reference model: accept, wait ten edges, publish, one idle edge with done
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 4'd0;
            m_out1 <= 21'd0;
            m_out0 <= 21'd0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 4'd1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_out1 <= fmt(m_val, m_mode, m_rem, m_neg, 1'b1);
                    m_out0 <= fmt(m_val, m_mode, m_rem, m_neg, 1'b0);
                end
                m_left <= m_left - 4'd1;
            end else if (!m_done && start) begin
                m_busy          <= 1'b1;
                m_left          <= 4'd9;
                m_mode          <= mode;
                m_rem           <= remainder;
                {m_neg, m_val}  <= cap(mode, result);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_out_blank", 32'(out1), 32'(m_out1));
        chk("cyc_out_plain", 32'(out0), 32'(m_out0));
        chk("cyc_flags", 32'({busy1, done1, busy0, done0}),
            32'({m_busy, m_done, m_busy, m_done}));
    end

    task automatic convert(input logic [1:0] md, input logic [7:0] res,
                           input logic [3:0] rm, output int lat);
        @(negedge clk);
        mode = md; result = res; remainder = rm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = ~md; result = ~res; remainder = ~rm;
        lat = 1;
        while (!done1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #20;
        chk("reset_out", 32'(out1), 32'd0);
        chk("reset_flags", 32'({busy1, done1, busy0, done0, out0}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        convert(2'b10, 8'd225, 4'd0, n);
        chk("mul225_latency", 32'(n), 32'd10);
        chk("mul225_dig", 32'({h1, t1, o1}), 32'h225);
        chk("mul225_rem", 32'({rt1, ro1, neg1}), 32'h1FE);
        chk("mul225_plain", 32'({h0, t0, o0, rt0, ro0}), 32'h22500);

        convert(2'b01, 8'h1D, 4'd0, n);
        chk("sub_neg_dig", 32'({h1, t1, o1, neg1}), 32'h1FE7);
        chk("sub_neg_plain", 32'({h0, t0, o0, neg0}), 32'h0007);

        convert(2'b11, 8'd3, 4'd3, n);
        chk("div15_4", 32'({h1, t1, o1, rt1, ro1}), 32'hFF3F3);

        convert(2'b00, 8'd0, 4'd0, n);
        chk("add_zero", 32'({h1, t1, o1}), 32'hFF0);
        convert(2'b00, 8'd30, 4'd0, n);
        chk("add_30", 32'({h1, t1, o1}), 32'hF30);
        chk("add_30_plain", 32'({h0, t0, o0}), 32'h030);

        convert(2'b11, 8'd255, 4'd15, n);
        chk("div_max", 32'({h1, t1, o1, rt1, ro1}), 32'h25515);
        chk("div_max_plain", 32'({h0, t0, o0, rt0, ro0}), 32'h25515);

        convert(2'b01, 8'hE5, 4'd0, n);
        chk("sub_pos_masked", 32'({h1, t1, o1, neg1}), 32'h1FEA);

        convert(2'b11, 8'd100, 4'd0, n);
        chk("div_100_r0", 32'({h1, t1, o1, rt1, ro1}), 32'h100F0);
        chk("div_100_r0_plain", 32'({rt0, ro0}), 32'h00);

        // start held high: back-to-back conversions, inputs moving mid-conversion
        @(negedge clk);
        mode = 2'b10; result = 8'd123; remainder = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        mode = 2'b00; result = 8'd77; remainder = 4'd2;
        n = 1;
        while (!done1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_first_lat", 32'(n), 32'd10);
        chk("hold_first_dig", 32'({h1, t1, o1, rt1, ro1}), 32'h123FF);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 3) result = 8'd200;
        end while (!done1 && n < 30);
        chk("hold_period", 32'(n), 32'd11);
        chk("hold_second_dig", 32'({h1, t1, o1}), 32'hF77);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // reset pulled mid-conversion
        @(negedge clk);
        mode = 2'b10; result = 8'd99; remainder = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out", 32'(out1), 32'd0);
        chk("abort_plain", 32'(out0), 32'd0);
        chk("abort_flags", 32'({busy1, done1, busy0, done0}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done1 || done0 || busy1) n++;
        end
        chk("abort_no_done", 32'(n), 32'd0);
        convert(2'b10, 8'd99, 4'd0, n);
        chk("after_abort_latency", 32'(n), 32'd10);
        chk("after_abort_dig", 32'({h1, t1, o1, rt1, ro1}), 32'hF99FF);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/calc_result_bcd.md
CALC_RESULT_BCD -- requirements
Module: calc_result_bcd

Interface
REQ-001 SHALL have parameter BLANK_LEAD, default 1; when 1, leading-zero digits are replaced by blank code 4'hF.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request to convert the current calculator output.
REQ-005 SHALL have port mode, input, 2 bits: calculator op code (00 add, 01 sub, 10 mul, 11 div).
REQ-006 SHALL have port result, input, 8 bits: calculator result (sub: bits[3:0] diff, bit[4] borrow).
REQ-007 SHALL have port remainder, input, 4 bits: division remainder.
REQ-008 SHALL have ports bcd_hun, bcd_ten and bcd_one, outputs, 4 bits each: result magnitude digits.
REQ-009 SHALL have ports rem_ten and rem_one, outputs, 4 bits each: remainder digits.
REQ-010 SHALL have port neg, output, 1 bit: result is negative.
REQ-011 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when the digit outputs update.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and FINISH.
REQ-014 SHALL accept start only in IDLE. At that edge it SHALL:
- latch mode, the conversion value and remainder;
- set busy = 1;
- clear the shift counter;
- enter SHIFT.
REQ-015 SHALL derive the conversion value at capture as follows:
- mode 01 with result[4] = 1: {4'b0, (~result[3:0] + 1) mod 16}, with neg_next = 1;
- mode 01 with result[4] = 0: {4'b0, result[3:0]}, with neg_next = 0;
- all other modes: result[7:0], with neg_next = 0.
REQ-016 SHALL perform one double-dabble iteration per clock in SHIFT, MSB first, 8 iterations for the result (12-bit BCD scratch). Each iteration SHALL add 3 to every BCD nibble >= 5, then shift left by 1.
REQ-017 SHALL convert the remainder in parallel with the result, 8-bit BCD scratch. The remainder shifts only on iterations 0-3 and holds on iterations 4-7.
REQ-018 SHALL move SHIFT to FINISH after iteration 7 (3-bit counter reaching 7).
REQ-019 In FINISH, SHALL:
- load all digit outputs and neg from the scratch registers;
- assert done for exactly that one cycle;
- deassert busy;
- return to IDLE on the next edge.
REQ-020 SHALL give a latency of 10 rising edges from the start-sampling edge to the edge after which done = 1: 1 capture, 8 shift, 1 finish.
REQ-021 SHALL ignore start while busy = 1 or done = 1; no re-latch, no restart.
REQ-022 SHALL hold the digit outputs and neg stable from one FINISH until the next FINISH; inputs changing during SHIFT SHALL have no effect.
REQ-023 When BLANK_LEAD = 1, SHALL set:
- bcd_hun = F if the hundreds digit is 0;
- bcd_ten = F if the hundreds and tens digits are both 0;
- rem_ten = F if the remainder tens digit is 0.
bcd_one and rem_one SHALL never be blanked.
REQ-024 When the latched mode != 11, SHALL set rem_ten = rem_one = F if BLANK_LEAD = 1, else 0.
REQ-025 When BLANK_LEAD = 0, SHALL output all digits as plain BCD 0-9.
REQ-026 SHALL keep every digit output at <= 9 or = F; no other codes are permitted.

Reset
REQ-027 SHALL, while rst_n = 0, immediately (asynchronously) force:
- state = IDLE;
- busy = 0, done = 0, neg = 0;
- all digit outputs = 0;
- counter and scratch registers = 0.
REQ-028 SHALL abort a conversion in progress when reset is asserted mid-SHIFT, without emitting done.
REQ-029 SHALL sample start no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL pass: mode 10, result 225, start pulse. Required: after exactly 10 edges done = 1; hun/ten/one = 2/2/5; neg = 0; rem_ten = rem_one = F.
REQ-031 SHALL pass: mode 01, result 8'h1D (3 - 6). Required: neg = 1; hun/ten/one = F/F/3.
REQ-032 SHALL pass: mode 11, result 3, remainder 3 (15 / 4). Required: one = 3, rem_one = 3, rem_ten = F, hun = ten = F.
REQ-033 SHALL pass: mode 00, result 0, then result 30. Required: 0 -> F/F/0; 30 -> F/3/0; ones digit never blanked.
REQ-034 SHALL pass: start held high continuously. Required: conversions repeat every 11 edges; start and input changes during SHIFT do not alter that conversion's output.
REQ-035 SHALL pass: rst_n pulled low at shift iteration 4 of a mode-10 conversion of result 99. Required: outputs = 0 immediately, no done pulse; after release, a new start converts correctly.
